// File: rtl/line_engine_if.sv
// Memory-request side of the line rasteriser: DDR address-FIFO and write-data-FIFO push ports.
// The engine drives through the master modport; the arbiter/FIFO side uses the slave modport.
interface line_engine_if;
    logic         af_full;
    logic         wdf_full;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;

    modport master (
        input  af_full, wdf_full,
        output af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );

    modport slave (
        output af_full, wdf_full,
        input  af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );
endinterface

// File: rtl/line_engine.sv
// Bresenham line rasteriser: one 2-beat masked DDR write burst per pixel; LE_CLIP_EN drops pixels outside 800x600.
// Latency: first BEAT0 two cycles after trigger, then 3 cycles per pixel with no backpressure.
// Backpressure: BEAT0 waits for af_full=0 and wdf_full=0, BEAT1 waits for wdf_full=0; state holds while stalled.
module line_engine (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   LE_color,
    input  logic [19:0]   LE_point,
    input  logic          LE_color_valid,
    input  logic          LE_point0_valid,
    input  logic          LE_point1_valid,
    input  logic          LE_trigger,
    input  logic [31:0]   LE_frame_base,
    line_engine_if.master mem,
    output logic          LE_ready,
    output logic          steep
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_STEP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [31:0] color_q;
    logic [19:0] p0_q, p1_q;

    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [9:0]  xend_q, xend_d;
    logic [9:0]  dx_q, dx_d;
    logic [9:0]  dy_q, dy_d;
    logic signed [11:0] err_q, err_d;
    logic        yneg_q, yneg_d;
    logic        steep_q, steep_d;

    // Only bits [27:22] of the frame base reach the burst address.
    logic unused_base;
    assign unused_base = ^{LE_frame_base[31:28], LE_frame_base[21:0]};

    // Line setup from the latched endpoints.
    logic [9:0] x0, y0, x1, y1;
    logic [9:0] adx, ady;
    logic [9:0] ax0, ay0, ax1, ay1;
    logic [9:0] sx0, sy0, sx1, sy1;
    logic [9:0] sdx, sdy;
    logic       steep_c, swap_c;

    always_comb begin
        x0      = p0_q[19:10];
        y0      = p0_q[9:0];
        x1      = p1_q[19:10];
        y1      = p1_q[9:0];
        adx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        ady     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        steep_c = (ady > adx);
        ax0     = steep_c ? y0 : x0;
        ay0     = steep_c ? x0 : y0;
        ax1     = steep_c ? y1 : x1;
        ay1     = steep_c ? x1 : y1;
        swap_c  = (ax0 > ax1);
        sx0     = swap_c ? ax1 : ax0;
        sy0     = swap_c ? ay1 : ay0;
        sx1     = swap_c ? ax0 : ax1;
        sy1     = swap_c ? ay0 : ay1;
        sdx     = sx1 - sx0;
        sdy     = (sy1 >= sy0) ? (sy1 - sy0) : (sy0 - sy1);
    end

    // Error term update for the step after the current pixel.
    logic signed [11:0] err_sub, err_add;
    assign err_sub = err_q - $signed({2'b00, dy_q});
    assign err_add = err_sub + $signed({2'b00, dx_q});

    // Screen-space pixel, burst address and per-beat byte masks.
    logic [9:0]   px, py;
    logic [30:0]  pix_addr;
    logic [15:0]  nib_mask;
    logic [15:0]  mask0, mask1;
    logic         pix_vis;

    assign px       = steep_q ? y_q : x_q;
    assign py       = steep_q ? x_q : y_q;
    assign pix_addr = {6'b000000, LE_frame_base[27:22], py, px[9:3], 2'b00};
    assign nib_mask = ~(16'hF000 >> {px[1:0], 2'b00});
    assign mask0    = px[2] ? 16'hFFFF : nib_mask;
    assign mask1    = px[2] ? nib_mask : 16'hFFFF;

`ifdef LE_CLIP_EN
    assign pix_vis = (px < 10'd800) && (py < 10'd600);
`else
    assign pix_vis = 1'b1;
`endif

    logic [30:0]  af_addr_c;
    logic         af_wr_en_c;
    logic [127:0] wdf_din_c;
    logic [15:0]  wdf_mask_c;
    logic         wdf_wr_en_c;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xend_d      = xend_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        yneg_d      = yneg_q;
        steep_d     = steep_q;
        af_addr_c   = 31'd0;
        af_wr_en_c  = 1'b0;
        wdf_din_c   = 128'd0;
        wdf_mask_c  = 16'hFFFF;
        wdf_wr_en_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (LE_trigger) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                steep_d = steep_c;
                x_d     = sx0;
                y_d     = sy0;
                xend_d  = sx1;
                dx_d    = sdx;
                dy_d    = sdy;
                yneg_d  = (sy1 < sy0);
                err_d   = $signed({3'b000, sdx[9:1]});
                state_d = S_BEAT0;
            end
            S_BEAT0: begin
                if (!pix_vis) begin
                    state_d = S_STEP;
                end else begin
                    af_addr_c  = pix_addr;
                    wdf_din_c  = {4{color_q}};
                    wdf_mask_c = mask0;
                    if (!mem.af_full && !mem.wdf_full) begin
                        af_wr_en_c  = 1'b1;
                        wdf_wr_en_c = 1'b1;
                        state_d     = S_BEAT1;
                    end
                end
            end
            S_BEAT1: begin
                // The address is already queued, so only the data FIFO can stall this beat.
                af_addr_c  = pix_addr;
                wdf_din_c  = {4{color_q}};
                wdf_mask_c = mask1;
                if (!mem.wdf_full) begin
                    wdf_wr_en_c = 1'b1;
                    state_d     = S_STEP;
                end
            end
            S_STEP: begin
                if (x_q == xend_q) begin
                    state_d = S_IDLE;
                end else begin
                    x_d     = x_q + 10'd1;
                    state_d = S_BEAT0;
                    if (err_sub < 0) begin
                        y_d   = yneg_q ? (y_q - 10'd1) : (y_q + 10'd1);
                        err_d = err_add;
                    end else begin
                        err_d = err_sub;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            xend_q  <= 10'd0;
            dx_q    <= 10'd0;
            dy_q    <= 10'd0;
            err_q   <= 12'sd0;
            yneg_q  <= 1'b0;
            steep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xend_q  <= xend_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            yneg_q  <= yneg_d;
            steep_q <= steep_d;
        end
    end

    // Endpoint/colour latches load in any state; the active line works from its own copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_q <= 32'd0;
            p0_q    <= 20'd0;
            p1_q    <= 20'd0;
        end else begin
            if (LE_color_valid)  color_q <= LE_color;
            if (LE_point0_valid) p0_q    <= LE_point;
            if (LE_point1_valid) p1_q    <= LE_point;
        end
    end

    assign mem.af_addr_din  = af_addr_c;
    assign mem.af_wr_en     = af_wr_en_c;
    assign mem.wdf_din      = wdf_din_c;
    assign mem.wdf_mask_din = wdf_mask_c;
    assign mem.wdf_wr_en    = wdf_wr_en_c;

    assign LE_ready = (state_q == S_IDLE);
    assign steep    = steep_q;

endmodule

// File: tb/tb_line_engine.sv
// Bench for line_engine: directed and random lines checked against a pixel-list model of the line rules.
`timescale 1ns/1ps
module tb_line_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] LE_color;
    logic [19:0] LE_point;
    logic        LE_color_valid;
    logic        LE_point0_valid;
    logic        LE_point1_valid;
    logic        LE_trigger;
    logic [31:0] LE_frame_base;
    logic        LE_ready;
    logic        steep;

    line_engine_if mif();

    line_engine dut (
        .clk             (clk),
        .rst             (rst),
        .LE_color        (LE_color),
        .LE_point        (LE_point),
        .LE_color_valid  (LE_color_valid),
        .LE_point0_valid (LE_point0_valid),
        .LE_point1_valid (LE_point1_valid),
        .LE_trigger      (LE_trigger),
        .LE_frame_base   (LE_frame_base),
        .mem             (mif),
        .LE_ready        (LE_ready),
        .steep           (steep)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bp_mode  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Captured FIFO traffic.
    logic [30:0]  cap_addr[$];
    logic [15:0]  cap_m0[$];
    logic [15:0]  cap_m1[$];
    logic [127:0] cap_d[$];
    int           cap_cyc[$];
    int           last_wdf_cyc = 0;
    int           viol = 0;
    bit           pending = 0;

    // Expected traffic from the model.
    logic [30:0]  exp_addr[$];
    logic [15:0]  exp_m0[$];
    logic [15:0]  exp_m1[$];
    bit           exp_steep;

    always @(negedge clk) begin
        if (!rst) begin
            pending = 0;
        end else begin
            if (mif.af_wr_en && (mif.af_full || mif.wdf_full)) viol++;
            if (mif.wdf_wr_en && mif.wdf_full) viol++;
            if (mif.af_wr_en && !mif.wdf_wr_en) viol++;
            if (mif.af_wr_en) begin
                if (pending) viol++;
                cap_addr.push_back(mif.af_addr_din);
                cap_m0.push_back(mif.wdf_mask_din);
                cap_d.push_back(mif.wdf_din);
                cap_cyc.push_back(cyc);
                pending = 1;
            end else if (mif.wdf_wr_en) begin
                if (!pending) viol++;
                cap_m1.push_back(mif.wdf_mask_din);
                cap_d.push_back(mif.wdf_din);
                last_wdf_cyc = cyc;
                pending = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: begin mif.af_full = ~mif.af_full; mif.wdf_full = 1'b0; end
                2: begin
                    mif.af_full  = ($urandom_range(0, 3) == 0);
                    mif.wdf_full = ($urandom_range(0, 3) == 0);
                end
                default: begin mif.af_full = 1'b0; mif.wdf_full = 1'b0; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit visible(input int px, input int py);
`ifdef LE_CLIP_EN
        return (px < 800) && (py < 600);
`else
        return (px >= 0) && (py >= 0);
`endif
    endfunction

    // Pixel list from the line rules, turned into expected bursts.
    task automatic model(input int x0, input int y0, input int x1, input int y1, input logic [31:0] base);
        int t, dx, dy, err, ys, y, px, py, k, a;
        logic [15:0] m;
        exp_addr.delete(); exp_m0.delete(); exp_m1.delete();
        exp_steep = (iabs(y1 - y0) > iabs(x1 - x0));
        if (exp_steep) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx = x1 - x0; dy = iabs(y1 - y0); err = dx / 2;
        ys = (y0 < y1) ? 1 : -1; y = y0;
        for (int x = x0; x <= x1; x++) begin
            px = exp_steep ? y : x;
            py = exp_steep ? x : y;
            if (visible(px, py)) begin
                k = px % 8;
                a = int'(base[27:22]) * 524288 + py * 512 + (px / 8) * 4;
                exp_addr.push_back(a[30:0]);
                m = 16'hFFFF;
                if (k < 4) m = m ^ (16'h000F << (4 * (3 - k)));
                exp_m0.push_back(m);
                m = 16'hFFFF;
                if (k >= 4) m = m ^ (16'h000F << (4 * (7 - k)));
                exp_m1.push_back(m);
            end
            err = err - dy;
            if (err < 0) begin y = y + ys; err = err + dx; end
        end
    endtask

    task automatic latch_line(input int x0, input int y0, input int x1, input int y1, input logic [31:0] color);
        @(posedge clk); #1;
        LE_color = color; LE_color_valid = 1'b1;
        LE_point = {10'(x0), 10'(y0)}; LE_point0_valid = 1'b1;
        @(posedge clk); #1;
        LE_color_valid = 1'b0; LE_point0_valid = 1'b0;
        LE_point = {10'(x1), 10'(y1)}; LE_point1_valid = 1'b1;
        @(posedge clk); #1;
        LE_point1_valid = 1'b0;
    endtask

    task automatic compare(input string tag, input logic [31:0] color);
        int errs, fb, n;
        errs = 0; fb = -1;
        chk({tag, " burst count"}, cap_addr.size(), exp_addr.size());
        chk({tag, " beat1 count"}, cap_m1.size(), exp_m1.size());
        chk({tag, " protocol"}, viol, 0);
        n = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (cap_addr[i] !== exp_addr[i] || cap_m0[i] !== exp_m0[i] ||
                (i < cap_m1.size() && cap_m1[i] !== exp_m1[i])) begin
                errs++;
                if (fb < 0) fb = i;
            end
        end
        foreach (cap_d[i]) if (cap_d[i] !== {4{color}}) errs++;
        chk({tag, " pixel errors"}, errs, 0);
        if (fb >= 0) begin
            chk($sformatf("%s addr[%0d]", tag, fb), cap_addr[fb], exp_addr[fb]);
            chk($sformatf("%s mask0[%0d]", tag, fb), cap_m0[fb], exp_m0[fb]);
        end
    endtask

    task automatic draw(input string tag, input int x0, input int y0, input int x1, input int y1,
                        input logic [31:0] color, input logic [31:0] base, input int bp,
                        input bit timing, input bit do_latch, input bit poke);
        int t_trig;
        bit done;
        if (do_latch) latch_line(x0, y0, x1, y1, color);
        LE_frame_base = base;
        model(x0, y0, x1, y1, base);
        cap_addr.delete(); cap_m0.delete(); cap_m1.delete(); cap_d.delete(); cap_cyc.delete();
        viol = 0;
        @(posedge clk); #1;
        bp_mode = bp;
        LE_trigger = 1'b1; t_trig = cyc;
        @(posedge clk); #1;
        LE_trigger = 1'b0;
        chk({tag, " busy after trigger"}, LE_ready, 1'b0);
        @(posedge clk); #1;
        chk({tag, " steep"}, steep, exp_steep);
        done = 0;
        for (int i = 0; i < 20000; i++) begin
            if (LE_ready) begin done = 1; break; end
            if (poke && i == 4) begin
                LE_trigger = 1'b1; LE_point = 20'hFFFFF; LE_point0_valid = 1'b1;
            end else if (poke && i == 5) begin
                LE_trigger = 1'b0; LE_point0_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        LE_trigger = 1'b0; LE_point0_valid = 1'b0;
        bp_mode = 0;
        chk({tag, " completes"}, done, 1'b1);
        compare(tag, color);
        if (timing && cap_cyc.size() > 0) begin
            chk({tag, " first beat latency"}, cap_cyc[0] - t_trig, 2);
            chk({tag, " burst span"}, last_wdf_cyc - cap_cyc[0], 3 * exp_addr.size() - 2);
        end
    endtask

    initial begin
        int x0, y0, x1, y1;
        rst = 1'b1;
        LE_color = '0; LE_point = '0; LE_color_valid = 1'b0;
        LE_point0_valid = 1'b0; LE_point1_valid = 1'b0; LE_trigger = 1'b0;
        LE_frame_base = '0; mif.af_full = 1'b0; mif.wdf_full = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("reset ready", LE_ready, 1'b1);
        chk("reset af_wr_en", mif.af_wr_en, 1'b0);
        chk("reset wdf_wr_en", mif.wdf_wr_en, 1'b0);
        chk("reset af_addr_din", mif.af_addr_din, 31'd0);
        chk("reset wdf_din", mif.wdf_din, 128'd0);
        chk("reset wdf_mask_din", mif.wdf_mask_din, 16'hFFFF);
        chk("reset steep", steep, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        draw("line1", 0, 0, 3, 0, 32'h007F0000, 32'h10400000, 0, 1, 1, 0);
        chk("line1 addr", cap_addr.size() > 0 ? cap_addr[0] : 31'h7FFFFFFF, 31'h0008_0000);
        if (cap_m0.size() == 4) begin
            chk("line1 m0[0]", cap_m0[0], 16'h0FFF);
            chk("line1 m0[1]", cap_m0[1], 16'hF0FF);
            chk("line1 m0[2]", cap_m0[2], 16'hFF0F);
            chk("line1 m0[3]", cap_m0[3], 16'hFFF0);
        end

        draw("vert", 0, 0, 0, 3, 32'h12345678, 32'h10400000, 0, 0, 1, 1);
        if (cap_addr.size() >= 2)
            chk("vert row stride", cap_addr[1] - cap_addr[0], 31'h200);

        draw("diag_rev", 800, 600, 0, 0, 32'hCAFEF00D, 32'h0FC00000, 0, 0, 1, 0);
        draw("steep653", 0, 0, 400, 652, 32'hA5A5A5A5, 32'h00400000, 0, 1, 1, 0);
        draw("bp_toggle", 0, 0, 3, 0, 32'h007F0000, 32'h10400000, 1, 0, 1, 0);

        for (int r = 0; r < 6; r++) begin
            x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 1023);
            x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 1023);
            draw($sformatf("rand%0d", r), x0, y0, x1, y1, $urandom, $urandom, (r % 2) * 2, 0, 1, 0);
        end
        x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 1023);
        draw("rand_point", x0, y0, x0, y0, $urandom, $urandom, 2, 0, 1, 0);

        latch_line(5, 5, 900, 300, 32'hDEADBEEF);
        @(posedge clk); #1 LE_trigger = 1'b1;
        @(posedge clk); #1 LE_trigger = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst ready", LE_ready, 1'b1);
        chk("midrst af_wr_en", mif.af_wr_en, 1'b0);
        chk("midrst wdf_wr_en", mif.wdf_wr_en, 1'b0);
        chk("midrst af_addr_din", mif.af_addr_din, 31'd0);
        chk("midrst wdf_din", mif.wdf_din, 128'd0);
        chk("midrst wdf_mask_din", mif.wdf_mask_din, 16'hFFFF);
        chk("midrst steep", steep, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        draw("after_rst", 0, 0, 0, 0, 32'h0, 32'h10400000, 0, 1, 0, 0);
        draw("after_rst2", 10, 20, 30, 25, 32'h00FF00FF, 32'h10400000, 0, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
